// File: rtl/sha256_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sha256_pkg
// Purpose  : Shared SHA-256 constants, message-schedule FSM state encoding
//            and the small sigma functions used by the schedule expansion
//            (the round datapath reuses these next to its big-sigma siblings).
// Ports    : n/a (package)
// Revision : 1.0 - initial release
// ============================================================================
package sha256_pkg;

  localparam int WORD_W      = 32;
  localparam int BLOCK_WORDS = 16;
  localparam int NUM_ROUNDS  = 64;

  // Message-schedule FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FULL = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  // sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3
  function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  // sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10
  function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/sha256_msg_expand.sv
`default_nettype none
// ============================================================================
// Module   : sha256_msg_expand
// Purpose  : Combinational next-word generator for the 16-entry schedule
//            window. With the window holding W[t..t+15], this produces
//            W[t+16] = sig1(W[t+14]) + W[t+9] + sig0(W[t+1]) + W[t].
// Ports    : w0, w1, w9, w14 - window taps r[0], r[1], r[9], r[14]
//            w_new           - expanded word, modulo 2^32
// Revision : 1.0 - initial release
// ============================================================================
module sha256_msg_expand
  import sha256_pkg::*;
(
  input  logic [31:0] w0,
  input  logic [31:0] w1,
  input  logic [31:0] w9,
  input  logic [31:0] w14,
  output logic [31:0] w_new
);

  assign w_new = sig1(w14) + w9 + sig0(w1) + w0;

endmodule
`default_nettype wire

// File: rtl/sha256_msg_schedule.sv
`default_nettype none
// ============================================================================
// Module   : sha256_msg_schedule
// Purpose  : SHA-256 message-schedule stage. Captures one 512-bit block as
//            16 words from a valid/ready upstream, then emits W[0..63], one
//            word per round advance, while cross-checking the external round
//            counter.
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            in_valid/in_ready  - upstream word handshake
//            in_word            - message word, word 0 first
//            blk_loaded         - 16 words held, waiting for start
//            soc_n              - active-low start (and abort while running)
//            rd                 - round advance
//            addr, eoc          - round counter index and end-of-count
//            w_t, w_valid       - schedule word for the current round
//            sched_err          - sticky schedule/counter mismatch
// Revision : 1.0 - initial release
// ============================================================================
module sha256_msg_schedule #(
  parameter int WORD_W      = 32,
  parameter int BLOCK_WORDS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  output logic              blk_loaded,
  input  logic              soc_n,
  input  logic              rd,
  input  logic [5:0]        addr,
  input  logic              eoc,
  output logic [WORD_W-1:0] w_t,
  output logic              w_valid,
  output logic              sched_err
);

  import sha256_pkg::*;

  logic [1:0]        state;
  logic [4:0]        count;     // words captured; reaches 16 on entry to FULL
  logic [5:0]        t_q;       // current round index
  logic [WORD_W-1:0] r [BLOCK_WORDS];
  logic [WORD_W-1:0] w_new;

  sha256_msg_expand u_expand (
    .w0    (r[0]),
    .w1    (r[1]),
    .w9    (r[9]),
    .w14   (r[14]),
    .w_new (w_new)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      count     <= '0;
      t_q       <= '0;
      sched_err <= 1'b0;
      for (int i = 0; i < BLOCK_WORDS; i++) begin
        r[i] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          // in_ready is high for the whole of IDLE; soc_n is ignored here
          if (in_valid) begin
            r[count[3:0]] <= in_word;
            if (count == 5'd15) begin
              count <= 5'd16;
              state <= ST_FULL;
            end else begin
              count <= count + 5'd1;
            end
          end
        end

        ST_FULL: begin
          if (!soc_n) begin
            state     <= ST_RUN;
            t_q       <= '0;
            sched_err <= 1'b0;
          end
        end

        ST_RUN: begin
          if (!soc_n) begin
            // Abort beats a simultaneous rd: no shift, block discarded,
            // error flag kept for whoever is watching it.
            state <= ST_IDLE;
            count <= '0;
          end else begin
            if ((addr != t_q) || eoc) begin
              sched_err <= 1'b1;
            end
            if (rd) begin
              for (int i = 0; i < BLOCK_WORDS - 1; i++) begin
                r[i] <= r[i+1];
              end
              r[BLOCK_WORDS-1] <= w_new;
              t_q              <= t_q + 6'd1;
              if (t_q == 6'd63) begin
                // Window is left stale; the next load overwrites it.
                state <= ST_IDLE;
                count <= '0;
              end
            end
          end
        end

        default: begin
          state <= ST_IDLE;
          count <= '0;
        end
      endcase
    end
  end

  assign in_ready   = (state == ST_IDLE);
  assign blk_loaded = (state == ST_FULL);
  assign w_valid    = (state == ST_RUN);
  assign w_t        = r[0];

endmodule
`default_nettype wire

// File: tb/tb_sha256_msg_schedule.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha256_msg_schedule
// Purpose  : Directed self-checking bench for sha256_msg_schedule.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_sha256_msg_schedule;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic        blk_loaded;
  logic        soc_n;
  logic        rd;
  logic [5:0]  addr;
  logic        eoc;
  logic [31:0] w_t;
  logic        w_valid;
  logic        sched_err;

  int tests = 0;
  int fails = 0;
  int tm    = 0;

  logic [31:0] blk  [16];
  logic [31:0] expw [64];

  always #5 clk = ~clk;

  sha256_msg_schedule #(.WORD_W(32), .BLOCK_WORDS(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_word    (in_word),
    .blk_loaded (blk_loaded),
    .soc_n      (soc_n),
    .rd         (rd),
    .addr       (addr),
    .eoc        (eoc),
    .w_t        (w_t),
    .w_valid    (w_valid),
    .sched_err  (sched_err)
  );

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] s0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  task automatic build_expected();
    for (int t = 0; t < 16; t++) expw[t] = blk[t];
    for (int t = 16; t < 64; t++)
      expw[t] = s1(expw[t-2]) + expw[t-7] + s0(expw[t-15]) + expw[t-16];
  endtask

  task automatic random_block();
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
    build_expected();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer blk[start .. start+n-1]; counts only handshaken words.
  task automatic load_words(input int start, input int n, input bit gappy);
    int got = 0;
    int cyc = 0;
    bit acc;
    while (got < n && cyc < 500) begin
      in_valid = gappy ? 1'($urandom_range(0, 1)) : 1'b1;
      in_word  = in_valid ? blk[start + got] : 32'hDEAD_BEEF;
      acc      = in_valid && in_ready;
      tick();
      if (acc) got++;
      cyc++;
    end
    in_valid = 1'b0;
    chk("load_count", got, n);
  endtask

  task automatic start();
    soc_n = 1'b0;
    tick();
    soc_n = 1'b1;
    tm    = 0;
    chk("start_w_valid", w_valid, 1'b1);
    chk("start_w0", w_t, blk[0]);
  endtask

  // Advance rounds until tm reaches upto, checking w_t every cycle.
  task automatic run(input int upto, input bit gapped);
    int cyc = 0;
    while (tm < upto && cyc < 400) begin
      addr = tm[5:0];
      rd   = gapped ? (cyc % 3 == 2) : 1'b1;
      chk($sformatf("w_t[%0d]", tm), w_t, expw[tm]);
      tick();
      if (rd) tm++;
      cyc++;
    end
    rd   = 1'b0;
    addr = tm[5:0];
    chk("run_reached", tm, upto);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},   in_ready,   1'b1);
    chk({tag, "_blk_loaded"}, blk_loaded, 1'b0);
    chk({tag, "_w_valid"},    w_valid,    1'b0);
    chk({tag, "_sched_err"},  sched_err,  1'b0);
    chk({tag, "_w_t"},        w_t,        32'h0);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_word  = '0;
    soc_n    = 1'b1;
    rd       = 1'b0;
    addr     = '0;
    eoc      = 1'b0;
    #1;
    chk_reset_outputs("reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // ---- "abc" block, back-to-back load, rd held high -----------------
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    blk[0]  = 32'h6162_6380;
    blk[15] = 32'h0000_0018;
    build_expected();
    load_words(0, 16, 1'b0);
    chk("abc_blk_loaded", blk_loaded, 1'b1);
    chk("abc_in_ready", in_ready, 1'b0);
    // A 17th word offered while full must not land anywhere
    in_valid = 1'b1;
    in_word  = 32'hFFFF_FFFF;
    tick();
    tick();
    in_valid = 1'b0;
    chk("full_still_loaded", blk_loaded, 1'b1);
    start();
    chk("abc_sched_err", sched_err, 1'b0);
    chk("abc_w16_const", expw[16], 32'h6162_6380);
    chk("abc_w17_const", expw[17], 32'h000F_0000);
    run(64, 1'b0);
    chk("abc_done_w_valid", w_valid, 1'b0);
    chk("abc_done_in_ready", in_ready, 1'b1);
    // Counter's end-of-count arrives after we left RUN: no error
    eoc = 1'b1;
    tick();
    eoc = 1'b0;
    chk("abc_eoc_idle_err", sched_err, 1'b0);

    // ---- backpressured load, gapped rd, forced addr error -------------
    random_block();
    load_words(0, 16, 1'b1);
    chk("bp_blk_loaded", blk_loaded, 1'b1);
    chk("bp_in_ready", in_ready, 1'b0);
    start();
    run(20, 1'b1);
    chk("gap_no_err", sched_err, 1'b0);
    addr = 6'd21;
    rd   = 1'b0;
    tick();
    chk("addr_err_set", sched_err, 1'b1);
    chk("addr_err_hold_w", w_t, expw[20]);
    run(64, 1'b0);
    chk("err_sticky_idle", sched_err, 1'b1);
    chk("err_idle_in_ready", in_ready, 1'b1);

    // ---- next block clears the error; abort at round 30 ---------------
    random_block();
    load_words(0, 16, 1'b0);
    chk("err_until_start", sched_err, 1'b1);
    start();
    chk("err_cleared", sched_err, 1'b0);
    run(30, 1'b0);
    soc_n = 1'b0;
    rd    = 1'b1;
    addr  = 6'd30;
    tick();
    soc_n = 1'b1;
    rd    = 1'b0;
    chk("abort_w_valid", w_valid, 1'b0);
    chk("abort_in_ready", in_ready, 1'b1);
    chk("abort_no_shift", w_t, expw[30]);
    chk("abort_err_held", sched_err, 1'b0);

    // ---- soc_n in IDLE with 5 words loaded is ignored -----------------
    random_block();
    load_words(0, 5, 1'b0);
    soc_n = 1'b0;
    tick();
    soc_n = 1'b1;
    chk("idle_soc_in_ready", in_ready, 1'b1);
    chk("idle_soc_w_valid", w_valid, 1'b0);
    load_words(5, 10, 1'b0);
    chk("fifteen_not_loaded", blk_loaded, 1'b0);
    load_words(15, 1, 1'b0);
    chk("sixteen_loaded", blk_loaded, 1'b1);
    start();
    run(64, 1'b0);

    // ---- async reset mid-load ------------------------------------------
    random_block();
    load_words(0, 7, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_load");
    tick();
    rst_n = 1'b1;

    // ---- full load, async reset mid-RUN --------------------------------
    random_block();
    load_words(0, 16, 1'b1);
    start();
    run(10, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_run");
    tick();
    rst_n = 1'b1;

    // ---- clean schedule after reset ------------------------------------
    random_block();
    load_words(0, 16, 1'b0);
    start();
    run(64, 1'b0);
    chk("final_idle", in_ready, 1'b1);
    chk("final_err", sched_err, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
